// File: rtl/lfsr_period_ctrl.sv
// Sequencer that seeds the external lfsr, counts cycles until the seed value 1 reappears and
// reports one period per LFSR width. Define LFSR_PERIOD_CHECK_EN to compare against maximal length.
module lfsr_period_ctrl #(
    parameter int CNT_W      = 12,
    parameter int MAX_CYCLES = 4095
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             sweep_all,
    input  logic [1:0]       cfg_mode,
    input  logic             abort,
    input  logic [10:0]      lfsr_out,
    output logic             lfsr_start,
    output logic             lfsr_stop,
    output logic [1:0]       lfsr_mode,
    output logic [CNT_W-1:0] period,
    output logic [1:0]       period_mode,
    output logic             period_timeout,
    output logic             period_ok,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEED   = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

    state_t           state;
    state_t           state_nxt;
    logic             sweep_q;
    logic [CNT_W-1:0] cnt;
    logic             seed_hit;
    logic             cnt_max;
    logic             more_modes;

    // cnt != 0 excludes the first RUN cycle, where the freshly loaded seed is still visible.
    assign seed_hit   = (lfsr_out == 11'd1) && (cnt != '0);
    assign cnt_max    = (cnt == MAX_CNT);
    assign more_modes = sweep_q && (lfsr_mode != 2'd3);

    // NOTE: every variable gets its default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = SEED;
            SEED:    state_nxt = RUN;
            RUN:     if (seed_hit || cnt_max) state_nxt = REPORT;
            REPORT:  if (period_ready) state_nxt = more_modes ? SEED : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_q        <= 1'b0;
            lfsr_mode      <= 2'd0;
            cnt            <= '0;
            period         <= '0;
            period_mode    <= 2'd0;
            period_timeout <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!abort) begin
                case (state)
                    IDLE: begin
                        if (go) begin
                            sweep_q   <= sweep_all;
                            lfsr_mode <= sweep_all ? 2'd0 : cfg_mode;
                        end
                    end
                    SEED: cnt <= '0;
                    RUN: begin
                        if (!cnt_max) cnt <= cnt + CNT_W'(1);
                        if (seed_hit) begin
                            period         <= cnt;
                            period_mode    <= lfsr_mode;
                            period_timeout <= 1'b0;
                        end else if (cnt_max) begin
                            period         <= MAX_CNT;
                            period_mode    <= lfsr_mode;
                            period_timeout <= 1'b1;
                        end
                    end
                    REPORT: begin
                        if (period_ready) begin
                            if (more_modes) lfsr_mode <= lfsr_mode + 2'd1;
                            else            done      <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LFSR_PERIOD_CHECK_EN
    logic [CNT_W-1:0] exp_period;

    always_comb begin
        exp_period = CNT_W'(255);
        case (lfsr_mode)
            2'd0: exp_period = CNT_W'(255);
            2'd1: exp_period = CNT_W'(511);
            2'd2: exp_period = CNT_W'(1023);
            2'd3: exp_period = CNT_W'(2047);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_ok <= 1'b0;
        end else if (!abort && (state == RUN)) begin
            if (seed_hit)     period_ok <= (cnt == exp_period);
            else if (cnt_max) period_ok <= 1'b0;
        end
    end
`else
    assign period_ok = 1'b0;
`endif

    assign lfsr_start   = (state == SEED);
    assign lfsr_stop    = (state == IDLE) || (state == REPORT);
    assign period_valid = (state == REPORT);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_lfsr_period_ctrl.sv
// Scoreboard bench for lfsr_period_ctrl: a behavioural 8..11-bit Galois LFSR closes the loop,
// stimulus queues hand-computed results and a monitor checks each accepted result.
module tb_lfsr_period_ctrl;

    localparam int CNT_W      = 12;
    localparam int MAX_CYCLES = 4095;
`ifdef LFSR_PERIOD_CHECK_EN
    localparam bit OK_EN = 1'b1;
`else
    localparam bit OK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             go = 1'b0;
    logic             sweep_all = 1'b0;
    logic [1:0]       cfg_mode = 2'd0;
    logic             abort = 1'b0;
    logic [10:0]      lfsr_out;
    logic             lfsr_start;
    logic             lfsr_stop;
    logic [1:0]       lfsr_mode;
    logic [CNT_W-1:0] period;
    logic [1:0]       period_mode;
    logic             period_timeout;
    logic             period_ok;
    logic             period_valid;
    logic             period_ready = 1'b1;
    logic             busy;
    logic             done;

    lfsr_period_ctrl #(.CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .sweep_all(sweep_all), .cfg_mode(cfg_mode),
        .abort(abort), .lfsr_out(lfsr_out), .lfsr_start(lfsr_start), .lfsr_stop(lfsr_stop),
        .lfsr_mode(lfsr_mode), .period(period), .period_mode(period_mode),
        .period_timeout(period_timeout), .period_ok(period_ok), .period_valid(period_valid),
        .period_ready(period_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the lfsr block: maximal-length Galois toggle masks per width
    logic [10:0] lfsr_q;
    logic        force_zero = 1'b0;

    function automatic logic [10:0] lfsr_step(input logic [10:0] s, input logic [1:0] m);
        logic [10:0] mask;
        logic [10:0] n;
        case (m)
            2'd0:    mask = 11'h0B8;
            2'd1:    mask = 11'h110;
            2'd2:    mask = 11'h240;
            default: mask = 11'h500;
        endcase
        n = s >> 1;
        if (s[0]) n = n ^ mask;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          lfsr_q <= 11'd1;
        else if (lfsr_start) lfsr_q <= 11'd1;
        else if (!lfsr_stop) lfsr_q <= lfsr_step(lfsr_q, lfsr_mode);
    end
    assign lfsr_out = force_zero ? 11'd0 : lfsr_q;

    typedef struct {
        logic [CNT_W-1:0] period;
        logic [1:0]       mode;
        logic             timeout;
        logic             ok;
    } res_t;

    res_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   overlap_cnt = 0;
    int   long_done_cnt = 0;
    int   e0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int p, input int m, input bit to);
        res_t r;
        r.period  = CNT_W'(p);
        r.mode    = 2'(m);
        r.timeout = to;
        r.ok      = OK_EN && !to;
        exp_q.push_back(r);
    endtask

    // Monitor: compares each result on the cycle it is accepted
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (period_valid && period_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: got result period %0d mode %0d, want none", period, period_mode);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("sb_period", 32'(period), 32'(e.period));
                    check("sb_mode", 32'(period_mode), 32'(e.mode));
                    check("sb_timeout", 32'(period_timeout), 32'(e.timeout));
                    check("sb_ok", 32'(period_ok), 32'(e.ok));
                end
            end
            if (done) done_cnt++;
            if (done && done_prev) long_done_cnt++;
            if (lfsr_start && lfsr_stop) overlap_cnt++;
            done_prev <= done;
        end else begin
            done_prev <= 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue_go(input bit sw, input logic [1:0] m);
        go        = 1'b1;
        sweep_all = sw;
        cfg_mode  = m;
        @(posedge clk);
        #1;
        e0        = cyc;
        go        = 1'b0;
        sweep_all = 1'b0;
        cfg_mode  = 2'd0;
    endtask

    task automatic wait_valid(input string name, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (period_valid) begin
                lat = cyc - e0;
                break;
            end
        end
        if (lat < 0) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string name, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - e0;
                break;
            end
        end
        if (lat < 0) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_start"}, 32'(lfsr_start), 32'd0);
        check({tag, "_stop"}, 32'(lfsr_stop), 32'd1);
        check({tag, "_lmode"}, 32'(lfsr_mode), 32'd0);
        check({tag, "_period"}, 32'(period), 32'd0);
        check({tag, "_pmode"}, 32'(period_mode), 32'd0);
        check({tag, "_tout"}, 32'(period_timeout), 32'd0);
        check({tag, "_ok"}, 32'(period_ok), 32'd0);
        check({tag, "_valid"}, 32'(period_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish before 1000000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int d0;
        int bad;
        int found;
        logic [CNT_W-1:0] p_hold;
        logic [10:0]      l_hold;

        #3;
        check_reset_vals("rst0");
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Single measurement, mode 0
        push_exp(255, 0, 1'b0);
        issue_go(1'b0, 2'd0);
        wait_valid("m0_valid", 400, lat);
        check("m0_valid_lat", 32'(lat), 32'd257);
        wait_done("m0_done", 10, lat);
        check("m0_done_lat", 32'(lat), 32'd258);
        tick(1);
        @(negedge clk);
        check("m0_idle", 32'(busy), 32'd0);
        tick(2);

        // Single measurement, mode 3, with a go during RUN that must be ignored
        push_exp(2047, 3, 1'b0);
        issue_go(1'b0, 2'd3);
        tick(20);
        go = 1'b1; sweep_all = 1'b1; cfg_mode = 2'd0;
        tick(1);
        go = 1'b0; sweep_all = 1'b0;
        @(negedge clk);
        check("m3_mode_held", 32'(lfsr_mode), 32'd3);
        wait_valid("m3_valid", 2200, lat);
        check("m3_valid_lat", 32'(lat), 32'd2049);
        wait_done("m3_done", 10, lat);
        tick(2);

        // Full sweep with immediate acceptance
        d0 = done_cnt;
        push_exp(255, 0, 1'b0);
        push_exp(511, 1, 1'b0);
        push_exp(1023, 2, 1'b0);
        push_exp(2047, 3, 1'b0);
        issue_go(1'b1, 2'd2);
        wait_done("sweep_done", 5000, lat);
        tick(3);
        check("sweep_done_count", 32'(done_cnt - d0), 32'd1);
        check("sweep_sb_drained", 32'(exp_q.size()), 32'd0);

        // Back-pressure on the first result of a sweep, then abort in mode 2 RUN
        period_ready = 1'b0;
        d0 = done_cnt;
        push_exp(255, 0, 1'b0);
        push_exp(511, 1, 1'b0);
        push_exp(1023, 2, 1'b0);
        push_exp(2047, 3, 1'b0);
        issue_go(1'b1, 2'd0);
        wait_valid("bp_valid", 400, lat);
        check("bp_valid_lat", 32'(lat), 32'd257);
        p_hold = period;
        l_hold = lfsr_out;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (period !== p_hold || lfsr_stop !== 1'b1 || lfsr_out !== l_hold || period_valid !== 1'b1)
                bad++;
        end
        check("bp_hold_stable", 32'(bad), 32'd0);
        check("bp_period", 32'(p_hold), 32'd255);
        tick(1);
        period_ready = 1'b1;
        tick(1);
        @(negedge clk);
        check("bp_next_seed", 32'(lfsr_start), 32'd1);
        check("bp_next_mode", 32'(lfsr_mode), 32'd1);
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (lfsr_mode == 2'd2 && busy && !lfsr_start && !lfsr_stop) begin
                found = 1;
                break;
            end
        end
        check("ab_reached_mode2", 32'(found), 32'd1);
        tick(100);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        @(negedge clk);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_valid", 32'(period_valid), 32'd0);
        check("ab_stop", 32'(lfsr_stop), 32'd1);
        check("ab_sb_left", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        tick(5);
        check("ab_no_done", 32'(done_cnt - d0), 32'd0);

        // abort and go together: stay IDLE
        abort = 1'b1; go = 1'b1; sweep_all = 1'b1;
        tick(1);
        abort = 1'b0; go = 1'b0; sweep_all = 1'b0;
        @(negedge clk);
        check("abgo_busy", 32'(busy), 32'd0);
        check("abgo_start", 32'(lfsr_start), 32'd0);
        tick(3);
        @(negedge clk);
        check("abgo_busy_later", 32'(busy), 32'd0);
        tick(1);

        // New sweep restarts from mode 0
        d0 = done_cnt;
        push_exp(255, 0, 1'b0);
        push_exp(511, 1, 1'b0);
        push_exp(1023, 2, 1'b0);
        push_exp(2047, 3, 1'b0);
        issue_go(1'b1, 2'd3);
        @(negedge clk);
        check("restart_seed", 32'(lfsr_start), 32'd1);
        check("restart_mode", 32'(lfsr_mode), 32'd0);
        wait_done("restart_done", 5000, lat);
        tick(3);
        check("restart_done_count", 32'(done_cnt - d0), 32'd1);
        check("restart_sb_drained", 32'(exp_q.size()), 32'd0);

        // Lock-up: lfsr_out stuck at 0 forces the timeout path
        force_zero = 1'b1;
        push_exp(MAX_CYCLES, 1, 1'b1);
        issue_go(1'b0, 2'd1);
        wait_valid("to_valid", 4300, lat);
        check("to_valid_lat", 32'(lat), 32'd4097);
        wait_done("to_done", 10, lat);
        check("to_done_lat", 32'(lat), 32'd4098);
        force_zero = 1'b0;
        tick(2);

        // Reset during RUN
        issue_go(1'b0, 2'd2);
        tick(100);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_run");
        tick(2);
        rst_n = 1'b1;
        tick(2);

        check("sb_final_drained", 32'(exp_q.size()), 32'd0);
        check("start_stop_overlap", 32'(overlap_cnt), 32'd0);
        check("done_single_cycle", 32'(long_done_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
